vixen_l1_l2_arbiter: RTL and testbench
======================================

Name: vixen_l1_l2_arbiter

Overview:
Arbitrates L1 I-cache and L1 D-cache miss/writeback requests onto the single L2 request port. It sits directly downstream of both L1 caches and upstream of L2. It allows one outstanding L2 transaction, with round-robin fairness between the two requesters. It also returns L2 read data to the winning cache, enforces an L2 response timeout, and keeps grant and conflict performance counters.

Parameters:
ADDR_W, 64, address width
LINE_W, 512, cache line data width
TIMEOUT_CYCLES, 1024, cycles to wait for l2_ack before aborting; must be >= 2

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous active-high reset
ic_req  in  1  I-cache L2 request (level, held until ic_ack)
ic_addr  in  ADDR_W  I-cache line address
ic_rdata  out  LINE_W  line returned to I-cache; valid when ic_ack=1
ic_ack  out  1  one-cycle completion pulse to I-cache
dc_req  in  1  D-cache L2 request (level, held until dc_ack)
dc_addr  in  ADDR_W  D-cache line address
dc_wdata  in  LINE_W  D-cache writeback line
dc_we  in  1  1 = write, 0 = read
dc_rdata  out  LINE_W  line returned to D-cache; valid when dc_ack=1
dc_ack  out  1  one-cycle completion pulse to D-cache
l2_req  out  1  L2 request, registered
l2_addr  out  ADDR_W  L2 address, registered
l2_wdata  out  LINE_W  L2 write data, registered
l2_we  out  1  L2 write enable, registered
l2_rdata  in  LINE_W  L2 read data; valid with l2_ack
l2_ack  in  1  L2 completion
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; set on timeout, cleared only by rst
perf_ic_grants  out  32  saturating count of I-cache grants
perf_dc_grants  out  32  saturating count of D-cache grants
perf_conflicts  out  32  saturating count of IDLE cycles with ic_req and dc_req both high

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. All outputs, including rdata buses, counters and timeout_err, become 0. rr_last=D, so the I-cache wins the first conflict. Reset mid-transaction abandons it with no ack pulse.
- States: IDLE, GRANT_I, GRANT_D, RESP.
- IDLE:
  - Only ic_req high -> GRANT_I.
  - Only dc_req high -> GRANT_D.
  - Both high -> grant the side that is not rr_last, and increment perf_conflicts.
  - On any grant: latch addr/wdata/we into the l2_* registers, set l2_req=1 the next cycle, update rr_last, and increment the grant counter.
  - An I-side grant always drives l2_we=0 and l2_wdata=0.
- GRANT_x:
  - l2_req and l2_addr/l2_wdata/l2_we are held stable until l2_ack.
  - l2_ack=1 -> capture l2_rdata into x_rdata, l2_req=0, -> RESP.
  - A timeout counter, cleared on grant, increments each GRANT cycle. When it reaches TIMEOUT_CYCLES-1 without l2_ack: l2_req=0, x_rdata=0, timeout_err=1, -> RESP. A late l2_ack arriving after the abort is ignored.
- RESP:
  - Exactly one of ic_ack/dc_ack pulses for one cycle. x_rdata holds its value until the next capture.
  - After the pulse -> IDLE.
  - For D-cache writes, dc_rdata holds the captured l2_rdata, which is don't-care.
- Requester contract: drop req in the cycle after ack. IDLE samples req on the edge after RESP, so it sees the dropped req and no double-grant occurs.
- Latency: if l2_ack arrives in the first cycle l2_req is high, the ack pulse appears 2 cycles after req was first sampled in IDLE. In general, ack is 1 cycle after l2_ack.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Inputs on the non-granted side are ignored until IDLE. A request that arrives mid-transaction waits.
- l2_ack in IDLE or RESP is ignored.

Test Plan:
1. Single I-cache read: ic_addr=0x1000, ic_req held, L2 acks with 0xAA.. on the first l2_req cycle -> l2_addr=0x1000, l2_we=0; ic_ack pulses 2 cycles after req with ic_rdata=0xAA..; perf_ic_grants=1.
2. D-cache writeback: dc_we=1, dc_addr=0x2040, dc_wdata=0x55.. -> l2_we=1, l2_wdata=0x55.., held stable across a 5-cycle L2 delay; dc_ack is a 1-cycle pulse; ic_ack stays 0.
3. Repeated conflict: both req high 4 times in a row, re-raised after each ack -> grant order I, D, I, D; perf_conflicts=4; perf_ic_grants=perf_dc_grants=2.
4. Mid-transaction arrival: dc_req rises while GRANT_I is waiting on L2 -> dc is untouched until ic_ack. Then dc is granted with no conflict counted, because ic_req has dropped.
5. Timeout with TIMEOUT_CYCLES=8 and l2_ack never asserted -> l2_req drops after 8 cycles; ic_ack pulses with ic_rdata=0; timeout_err=1 and stays 1 through later good transactions.
6. Reset mid-transaction: rst=1 during GRANT_D -> next cycle l2_req=0, busy=0, counters=0, and no dc_ack. After rst release with both req high, I-cache wins.

Source files
------------

// File: rtl/vixen_l1_l2_arbiter.sv
// L1 I/D -> L2 request arbiter.
// One outstanding L2 transaction, round-robin between the caches on conflict,
// L2 response timeout with sticky error, saturating performance counters.
module vixen_l1_l2_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int LINE_W         = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_ack,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  input  logic              dc_we,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_ack,
  output logic              l2_req,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  output logic              l2_we,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_ack,
  output logic              busy,
  output logic              timeout_err,
  output logic [31:0]       perf_ic_grants,
  output logic [31:0]       perf_dc_grants,
  output logic [31:0]       perf_conflicts
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_e;

  // rr_last encoding: 0 = I-cache won last, 1 = D-cache won last
  localparam logic RR_I = 1'b0;
  localparam logic RR_D = 1'b1;

  state_e            state_q;
  logic              rr_last_q;
  logic [CNT_W-1:0]  tmo_q;
  logic [LINE_W-1:0] ic_rdata_q, dc_rdata_q;
  logic              ic_ack_q, dc_ack_q;
  logic              l2_req_q, l2_we_q;
  logic [ADDR_W-1:0] l2_addr_q;
  logic [LINE_W-1:0] l2_wdata_q;
  logic              tmo_err_q;
  logic [31:0]       ic_cnt_q, dc_cnt_q, cf_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Arbitration FSM; every output is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_last_q  <= RR_D;
      tmo_q      <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      ic_ack_q   <= 1'b0;
      dc_ack_q   <= 1'b0;
      l2_req_q   <= 1'b0;
      l2_we_q    <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
      tmo_err_q  <= 1'b0;
      ic_cnt_q   <= '0;
      dc_cnt_q   <= '0;
      cf_cnt_q   <= '0;
    end else begin
      // acks are single-cycle pulses raised on the way into RESP
      ic_ack_q <= 1'b0;
      dc_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ic_req && dc_req) cf_cnt_q <= sat_inc(cf_cnt_q);
          if (ic_req && (!dc_req || rr_last_q == RR_D)) begin
            state_q    <= GRANT_I;
            rr_last_q  <= RR_I;
            tmo_q      <= '0;
            l2_req_q   <= 1'b1;
            l2_addr_q  <= ic_addr;
            l2_wdata_q <= '0;
            l2_we_q    <= 1'b0;
            ic_cnt_q   <= sat_inc(ic_cnt_q);
          end else if (dc_req) begin
            state_q    <= GRANT_D;
            rr_last_q  <= RR_D;
            tmo_q      <= '0;
            l2_req_q   <= 1'b1;
            l2_addr_q  <= dc_addr;
            l2_wdata_q <= dc_wdata;
            l2_we_q    <= dc_we;
            dc_cnt_q   <= sat_inc(dc_cnt_q);
          end
        end
        GRANT_I, GRANT_D: begin
          // an ack in the final allowed cycle still counts as a good response
          if (l2_ack) begin
            if (state_q == GRANT_I) begin
              ic_rdata_q <= l2_rdata;
              ic_ack_q   <= 1'b1;
            end else begin
              dc_rdata_q <= l2_rdata;
              dc_ack_q   <= 1'b1;
            end
            l2_req_q <= 1'b0;
            state_q  <= RESP;
          end else if (tmo_q == TMO_LAST) begin
            if (state_q == GRANT_I) begin
              ic_rdata_q <= '0;
              ic_ack_q   <= 1'b1;
            end else begin
              dc_rdata_q <= '0;
              dc_ack_q   <= 1'b1;
            end
            l2_req_q  <= 1'b0;
            tmo_err_q <= 1'b1;
            state_q   <= RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ic_rdata       = ic_rdata_q;
  assign dc_rdata       = dc_rdata_q;
  assign ic_ack         = ic_ack_q;
  assign dc_ack         = dc_ack_q;
  assign l2_req         = l2_req_q;
  assign l2_addr        = l2_addr_q;
  assign l2_wdata       = l2_wdata_q;
  assign l2_we          = l2_we_q;
  assign busy           = (state_q != IDLE);
  assign timeout_err    = tmo_err_q;
  assign perf_ic_grants = ic_cnt_q;
  assign perf_dc_grants = dc_cnt_q;
  assign perf_conflicts = cf_cnt_q;

endmodule

// File: tb/tb_vixen_l1_l2_arbiter.sv
// Directed bench for vixen_l1_l2_arbiter; L2 side driven by hand per scenario.
module tb_vixen_l1_l2_arbiter;

  localparam int AW = 64;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req, dc_req, dc_we, l2_ack;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata, l2_rdata;
  logic [LW-1:0] ic_rdata, dc_rdata, l2_wdata;
  logic          ic_ack, dc_ack, l2_req, l2_we, busy, timeout_err;
  logic [AW-1:0] l2_addr;
  logic [31:0]   perf_ic_grants, perf_dc_grants, perf_conflicts;

  int n_chk  = 0;
  int n_pass = 0;

  logic [LW-1:0] D_AA, D_55, D_33, D_C3;

  vixen_l1_l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_we(dc_we),
    .dc_rdata(dc_rdata), .dc_ack(dc_ack),
    .l2_req(l2_req), .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_we(l2_we),
    .l2_rdata(l2_rdata), .l2_ack(l2_ack),
    .busy(busy), .timeout_err(timeout_err),
    .perf_ic_grants(perf_ic_grants), .perf_dc_grants(perf_dc_grants),
    .perf_conflicts(perf_conflicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; l2_ack = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; l2_rdata = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    D_AA = {64{8'hAA}};
    D_55 = {64{8'h55}};
    D_33 = {64{8'h33}};
    D_C3 = {64{8'hC3}};
    do_reset();

    // reset state
    chk("rst_l2_req",  512'(l2_req), 512'(0));
    chk("rst_busy",    512'(busy), 512'(0));
    chk("rst_ic_ack",  512'(ic_ack), 512'(0));
    chk("rst_dc_ack",  512'(dc_ack), 512'(0));
    chk("rst_tmo",     512'(timeout_err), 512'(0));
    chk("rst_ic_rd",   ic_rdata, '0);
    chk("rst_perf",    512'({perf_ic_grants, perf_dc_grants, perf_conflicts}), 512'(0));

    // 1: single I-cache read, L2 acks on first l2_req cycle
    ic_addr = 64'h1000; ic_req = 1'b1;
    tick();
    chk("t1_l2_req",  512'(l2_req), 512'(1));
    chk("t1_l2_addr", 512'(l2_addr), 512'(64'h1000));
    chk("t1_l2_we",   512'(l2_we), 512'(0));
    chk("t1_busy",    512'(busy), 512'(1));
    l2_ack = 1'b1; l2_rdata = D_AA;
    tick();
    l2_ack = 1'b0; l2_rdata = '0;
    chk("t1_ic_ack",   512'(ic_ack), 512'(1));
    chk("t1_ic_rdata", ic_rdata, D_AA);
    chk("t1_l2_drop",  512'(l2_req), 512'(0));
    chk("t1_ic_cnt",   512'(perf_ic_grants), 512'(1));
    tick();
    chk("t1_ack_pulse", 512'(ic_ack), 512'(0));
    chk("t1_idle",      512'(busy), 512'(0));
    ic_req = 1'b0;
    tick();
    chk("t1_no_regrant", 512'(busy), 512'(0));

    // 2: D-cache writeback held across 5-cycle L2 delay
    do_reset();
    dc_we = 1'b1; dc_addr = 64'h2040; dc_wdata = D_55; dc_req = 1'b1;
    tick();
    chk("t2_l2_we",    512'(l2_we), 512'(1));
    chk("t2_l2_wdata", l2_wdata, D_55);
    chk("t2_l2_addr",  512'(l2_addr), 512'(64'h2040));
    dc_wdata = '0; dc_addr = 64'hDEAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_req",   512'(l2_req), 512'(1));
      chk("t2_hold_wdata", l2_wdata, D_55);
      chk("t2_hold_addr",  512'(l2_addr), 512'(64'h2040));
      chk("t2_no_ack",     512'(dc_ack), 512'(0));
    end
    l2_ack = 1'b1; l2_rdata = D_C3;
    tick();
    l2_ack = 1'b0;
    chk("t2_dc_ack", 512'(dc_ack), 512'(1));
    chk("t2_ic_ack", 512'(ic_ack), 512'(0));
    tick();
    chk("t2_dc_pulse", 512'(dc_ack), 512'(0));
    dc_req = 1'b0;
    tick();
    chk("t2_dc_cnt", 512'(perf_dc_grants), 512'(1));
    chk("t2_ic_cnt", 512'(perf_ic_grants), 512'(0));

    // 3: four back-to-back conflicts alternate I, D, I, D
    do_reset();
    ic_addr = 64'h100; dc_addr = 64'h200; dc_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ic_req = 1'b1; dc_req = 1'b1;
      tick();
      chk("t3_grant_addr", 512'(l2_addr), (k % 2 == 0) ? 512'(64'h100) : 512'(64'h200));
      l2_ack = 1'b1; l2_rdata = D_33;
      tick();
      l2_ack = 1'b0;
      chk("t3_ic_ack", 512'(ic_ack), 512'(k % 2 == 0));
      chk("t3_dc_ack", 512'(dc_ack), 512'(k % 2 == 1));
      tick();
      ic_req = 1'b0; dc_req = 1'b0;
      tick();
    end
    chk("t3_conflicts", 512'(perf_conflicts), 512'(4));
    chk("t3_ic_cnt",    512'(perf_ic_grants), 512'(2));
    chk("t3_dc_cnt",    512'(perf_dc_grants), 512'(2));

    // 4: D request arriving while I waits on L2
    do_reset();
    ic_addr = 64'h1100; ic_req = 1'b1;
    tick();
    dc_addr = 64'h3000; dc_we = 1'b0; dc_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t4_still_i",  512'(l2_addr), 512'(64'h1100));
    chk("t4_dc_quiet", 512'(dc_ack), 512'(0));
    l2_ack = 1'b1; l2_rdata = D_AA;
    tick();
    l2_ack = 1'b0;
    chk("t4_ic_ack", 512'(ic_ack), 512'(1));
    chk("t4_dc_ack", 512'(dc_ack), 512'(0));
    tick();
    ic_req = 1'b0;
    tick();
    chk("t4_d_addr",    512'(l2_addr), 512'(64'h3000));
    chk("t4_d_req",     512'(l2_req), 512'(1));
    chk("t4_no_confl",  512'(perf_conflicts), 512'(0));
    chk("t4_dc_cnt",    512'(perf_dc_grants), 512'(1));
    l2_ack = 1'b1; l2_rdata = D_55;
    tick();
    l2_ack = 1'b0;
    chk("t4_dc_done",  512'(dc_ack), 512'(1));
    chk("t4_dc_rdata", dc_rdata, D_55);
    tick();
    dc_req = 1'b0;
    tick();

    // 5: timeout after 8 GRANT cycles, sticky error
    do_reset();
    ic_addr = 64'h4000; ic_req = 1'b1;
    tick();
    l2_ack = 1'b1; l2_rdata = D_AA;
    tick();
    l2_ack = 1'b0;
    chk("t5_pre_rdata", ic_rdata, D_AA);
    tick();
    ic_req = 1'b0;
    tick();
    ic_req = 1'b1;
    tick();
    chk("t5_req_up", 512'(l2_req), 512'(1));
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t5_req_held", 512'(l2_req), 512'(1));
    end
    tick();
    chk("t5_req_drop", 512'(l2_req), 512'(0));
    chk("t5_ic_ack",   512'(ic_ack), 512'(1));
    chk("t5_rdata0",   ic_rdata, '0);
    chk("t5_err",      512'(timeout_err), 512'(1));
    l2_ack = 1'b1; l2_rdata = D_C3;
    tick();
    l2_ack = 1'b0;
    chk("t5_late_ign", ic_rdata, '0);
    chk("t5_ack_once", 512'(ic_ack), 512'(0));
    ic_req = 1'b0;
    tick();
    ic_req = 1'b1;
    tick();
    l2_ack = 1'b1; l2_rdata = D_33;
    tick();
    l2_ack = 1'b0;
    chk("t5_good_rd",  ic_rdata, D_33);
    chk("t5_err_stck", 512'(timeout_err), 512'(1));
    tick();
    ic_req = 1'b0;
    tick();

    // 6: reset during GRANT_D abandons the transaction
    do_reset();
    dc_addr = 64'h5000; dc_we = 1'b1; dc_wdata = D_55; dc_req = 1'b1;
    tick();
    chk("t6_busy", 512'(busy), 512'(1));
    rst = 1'b1;
    tick();
    chk("t6_l2_req", 512'(l2_req), 512'(0));
    chk("t6_busy0",  512'(busy), 512'(0));
    chk("t6_cnt0",   512'(perf_dc_grants), 512'(0));
    chk("t6_no_ack", 512'(dc_ack), 512'(0));
    rst = 1'b0; ic_addr = 64'h6000; ic_req = 1'b1;
    tick();
    chk("t6_i_wins", 512'(l2_addr), 512'(64'h6000));
    chk("t6_i_we",   512'(l2_we), 512'(0));
    chk("t6_confl",  512'(perf_conflicts), 512'(1));
    chk("t6_no_dack", 512'(dc_ack), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
